// File: rtl/mem_access_if.sv
// Word-wide data bus between the MEM stage and the memory.
// The master issues requests; the slave returns ack and read data.
interface mem_access_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/mem_access.sv
// MEM-stage load/store unit: alignment check, lane steering,
// bus handshake with timeout, and load extension.
module mem_access #(
    parameter int TIMEOUT = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         MemRead,
    input  logic         MemWrite,
    input  logic [1:0]   lbSel,
    input  logic [31:0]  ALUResultM,
    input  logic [31:0]  ReadData2M,
    mem_access_if.master bus,
    output logic         stallM,
    output logic [31:0]  LoadDataM,
    output logic         misalignM,
    output logic         bus_errM
);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_e;

    state_e        state_q, state_d;
    logic          req_q, req_d;
    logic          we_q, we_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [3:0]    be_q, be_d;
    logic [31:0]   load_q, load_d;
    logic          err_q, err_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    sel_q, sel_d;
    logic [1:0]    off_q, off_d;

    logic          access;
    logic          aligned;
    logic          timeout;
    logic [31:0]   st_data;
    logic [3:0]    st_be;
    logic [7:0]    ld_byte;
    logic [15:0]   ld_half;
    logic [31:0]   ld_ext;

    always_comb begin
        access  = MemRead | MemWrite;
        timeout = (cnt_q == CW'(TIMEOUT - 1));
        unique case (lbSel)
            2'b00:   aligned = (ALUResultM[1:0] == 2'b00);
            2'b10:   aligned = ~ALUResultM[0];
            default: aligned = 1'b1;
        endcase
    end

    // Store lanes: narrow data is replicated so any lane sees it.
    always_comb begin
        unique case (lbSel)
            2'b00: begin
                st_data = ReadData2M;
                st_be   = 4'b1111;
            end
            2'b10: begin
                st_data = {2{ReadData2M[15:0]}};
                st_be   = ALUResultM[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                st_data = {4{ReadData2M[7:0]}};
                st_be   = 4'b0001 << ALUResultM[1:0];
            end
        endcase
    end

    always_comb begin
        ld_byte = bus.mem_rdata[8*off_q +: 8];
        ld_half = off_q[1] ? bus.mem_rdata[31:16]
                           : bus.mem_rdata[15:0];
        unique case (sel_q)
            2'b00: ld_ext = bus.mem_rdata;
            2'b01: ld_ext = {{24{ld_byte[7]}}, ld_byte};
            2'b10: ld_ext = {{16{ld_half[15]}}, ld_half};
            2'b11: ld_ext = {24'd0, ld_byte};
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            load_q  <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
            sel_q   <= '0;
            off_q   <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            load_q  <= load_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            off_q   <= off_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (access && aligned) state_d = REQ;
            REQ:     if (bus.mem_ack || timeout) state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        load_d  = load_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        off_d   = off_q;
        unique case (state_q)
            IDLE: begin
                if (access && aligned) begin
                    req_d   = 1'b1;
                    we_d    = MemWrite;
                    addr_d  = {ALUResultM[31:2], 2'b00};
                    wdata_d = st_data;
                    be_d    = MemWrite ? st_be : 4'b0000;
                    sel_d   = lbSel;
                    off_d   = ALUResultM[1:0];
                    cnt_d   = '0;
                    err_d   = 1'b0;
                end
            end
            REQ: begin
                if (bus.mem_ack || timeout) begin
                    req_d  = 1'b0;
                    we_d   = 1'b0;
                    be_d   = 4'b0000;
                    err_d  = ~bus.mem_ack;
                    load_d = (bus.mem_ack && !we_q) ? ld_ext : '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: err_d = 1'b0;
        endcase
    end

    // Gated by rst so a held reset never stalls the pipeline.
    always_comb begin
        stallM    = rst & ((state_q == IDLE && access && aligned)
                          || state_q == REQ);
        misalignM = rst & (state_q == IDLE) & access & ~aligned;
    end

    assign bus.mem_req   = req_q;
    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.mem_be    = be_q;
    assign LoadDataM     = load_q;
    assign bus_errM      = err_q;
endmodule

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 Parameter TIMEOUT, default 16, SHALL set the cycle count in REQ without mem_ack before a bus error abort.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 MemRead  input  1  SHALL be the load request from the EX/MEM pipeline register.
REQ-005 MemWrite  input  1  SHALL be the store request from the EX/MEM pipeline register.
REQ-006 lbSel  input  2  SHALL select access size: 00 word, 01 signed byte, 10 signed half, 11 unsigned byte.
REQ-007 ALUResultM  input  32  SHALL be the byte address.
REQ-008 ReadData2M  input  32  SHALL be the store data.
REQ-009 mem_req, mem_we  output  1 each  SHALL be the bus request and write strobe.
REQ-010 mem_addr  output  32  SHALL be the word-aligned address, {ALUResultM[31:2],2'b00}.
REQ-011 mem_wdata  output  32, mem_be  output  4  SHALL be the write data and byte enables.
REQ-012 mem_ack  input  1, mem_rdata  input  32  SHALL be the bus completion and read data.
REQ-013 stallM  output  1  SHALL freeze the IF through EX/MEM stages while high.
REQ-014 LoadDataM  output  32  SHALL be the extended load result for MEM/WB.
REQ-015 misalignM, bus_errM  output  1 each  SHALL flag an alignment fault and a bus timeout.

Function
REQ-016 FSM SHALL have states IDLE, REQ, DONE.
REQ-017 Access = MemRead|MemWrite; half is aligned iff addr[0]=0, word iff addr[1:0]=00, byte always aligned.
REQ-018 In IDLE with an aligned access, stallM SHALL be high combinationally and the next state SHALL be REQ with mem_req=1 and bus outputs registered.
REQ-019 In IDLE with a misaligned access, misalignM SHALL be high combinationally, stallM low, no bus request issued, state stays IDLE.
REQ-020 If MemRead and MemWrite are both high, write SHALL take priority and the read SHALL be ignored.
REQ-021 In REQ, mem_req and stallM SHALL stay high and bus outputs stable until mem_ack is seen or the timeout expires.
REQ-022 In REQ, mem_ack=1 SHALL move to DONE, capturing the extended load into LoadDataM for reads.
REQ-023 The timeout counter SHALL clear on entering REQ and increment each REQ cycle without ack; at TIMEOUT it SHALL move to DONE with bus_errM=1 and LoadDataM=0.
REQ-024 DONE SHALL last exactly one cycle with stallM low; LoadDataM and bus_errM are valid in this cycle, then the FSM returns to IDLE without re-sampling inputs.
REQ-025 mem_ack SHALL be ignored outside REQ.
REQ-026 Minimum latency: access in cycle 0, ack in cycle 1, result in cycle 2; stall high for cycles 0 and 1.
REQ-027 Loads SHALL be little-endian: the byte lane is addr[1:0] and the half lane is addr[1].
REQ-028 Loads SHALL sign-extend for lbSel 01/10, zero-extend for 11, and pass the word for 00.
REQ-029 Stores SHALL replicate the byte into all 4 lanes for sb and the half into both halves for sh.
REQ-030 mem_be SHALL be 1<<addr[1:0] for bytes, 0011 or 1100 for half, 1111 for word, and 0000 on reads.

Reset
REQ-031 rst low SHALL immediately force IDLE, mem_req=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0, LoadDataM=0, bus_errM=0, counter=0, and stallM=0 and misalignM=0 while held.
REQ-032 Reset asserted mid-REQ SHALL drop mem_req in the same cycle with no retry after release.

Verification
REQ-033 lb from addr 0x103, rdata 0x80FF_FF00, ack after 1 cycle -> LoadDataM 0xFFFF_FF80 in DONE, stall 2 cycles.
REQ-034 sh at addr 0x202 with ReadData2M 0x0000_BEEF -> mem_wdata 0xBEEF_BEEF, mem_be 1100, mem_we=1.
REQ-035 lw at addr 0x006 -> misalignM=1, stallM=0, mem_req never asserted.
REQ-036 lw with no ack, TIMEOUT=16 -> mem_req high for 16 cycles, then DONE with bus_errM=1 and LoadDataM=0.
REQ-037 MemRead and MemWrite both high at addr 0x10, lbSel 00 -> write bus cycle with mem_be 1111.
REQ-038 rst low during REQ with ack pending -> mem_req 0 immediately; a later ack has no effect and the FSM stays in IDLE.
